mem_bus_arbiter: RTL

//  Shares one single-port memory bus (SRAM/ROM side) between the CPU ibus and dbus masters.

---
 rtl/mem_bus_arbiter_if.sv | 46 ++++
 rtl/mem_bus_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - ibus/dbus/memory signal bundle around the memory bus arbiter
interface mem_bus_arbiter_if;
    logic [31:0] ibus_address;
    logic [3:0]  ibus_byteenable;
    logic        ibus_read;
    logic        ibus_write;
    logic [31:0] ibus_wrdata;
    logic [31:0] ibus_rddata;
    logic        ibus_stall;

    logic [31:0] dbus_address;
    logic [3:0]  dbus_byteenable;
    logic        dbus_read;
    logic        dbus_write;
    logic [31:0] dbus_wrdata;
    logic [31:0] dbus_rddata;
    logic        dbus_stall;

    logic [31:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wrdata;
    logic [31:0] mem_rddata;
    logic        mem_waitrequest;

    // Arbiter side
    modport slave (
        input  ibus_address, ibus_byteenable, ibus_read, ibus_write, ibus_wrdata,
        output ibus_rddata, ibus_stall,
        input  dbus_address, dbus_byteenable, dbus_read, dbus_write, dbus_wrdata,
        output dbus_rddata, dbus_stall,
        output mem_address, mem_byteenable, mem_read, mem_write, mem_wrdata,
        input  mem_rddata, mem_waitrequest
    );

    // CPU masters plus memory controller
    modport master (
        output ibus_address, ibus_byteenable, ibus_read, ibus_write, ibus_wrdata,
        input  ibus_rddata, ibus_stall,
        output dbus_address, dbus_byteenable, dbus_read, dbus_write, dbus_wrdata,
        input  dbus_rddata, dbus_stall,
        input  mem_address, mem_byteenable, mem_read, mem_write, mem_wrdata,
        output mem_rddata, mem_waitrequest
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single-port memory bus arbiter, dbus priority with bounded ibus starvation
module mem_bus_arbiter #(
    parameter int MAX_DBUS_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_bus_arbiter_if.slave    bus,
    output logic [1:0]          owner,
    output logic                protocol_err
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DBUS_STREAK);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_t;

    state_t     state;
    logic [3:0] streak;

    logic ibus_req;
    logic dbus_req;
    logic ibus_starved;

    assign ibus_req     = bus.ibus_read | bus.ibus_write;
    assign dbus_req     = bus.dbus_read | bus.dbus_write;
    assign ibus_starved = ibus_req && (streak == STREAK_MAX);

    logic [31:0] mem_address_c;
    logic [3:0]  mem_byteenable_c;
    logic        mem_read_c;
    logic        mem_write_c;
    logic [31:0] mem_wrdata_c;
    logic        ibus_stall_c;
    logic        dbus_stall_c;
    logic [31:0] ibus_rddata_c;
    logic [31:0] dbus_rddata_c;

    // Bus steering is combinational from the registered grant so the strobe
    // appears one cycle after the request and drops the instant reset or a
    // dropped request is seen.
    always_comb begin
        mem_address_c    = 32'h0;
        mem_byteenable_c = 4'h0;
        mem_read_c       = 1'b0;
        mem_write_c      = 1'b0;
        mem_wrdata_c     = 32'h0;
        ibus_stall_c     = ibus_req;
        dbus_stall_c     = dbus_req;
        ibus_rddata_c    = 32'h0;
        dbus_rddata_c    = 32'h0;
        case (state)
            GNT_I: begin
                mem_address_c    = bus.ibus_address;
                mem_byteenable_c = bus.ibus_byteenable;
                mem_wrdata_c     = bus.ibus_wrdata;
                if (ibus_req) begin
                    mem_write_c = bus.ibus_write;
                    mem_read_c  = bus.ibus_read & ~bus.ibus_write;
                    if (!bus.mem_waitrequest) begin
                        ibus_stall_c  = 1'b0;
                        ibus_rddata_c = bus.mem_rddata;
                    end
                end
            end
            GNT_D: begin
                mem_address_c    = bus.dbus_address;
                mem_byteenable_c = bus.dbus_byteenable;
                mem_wrdata_c     = bus.dbus_wrdata;
                if (dbus_req) begin
                    mem_write_c = bus.dbus_write;
                    mem_read_c  = bus.dbus_read & ~bus.dbus_write;
                    if (!bus.mem_waitrequest) begin
                        dbus_stall_c  = 1'b0;
                        dbus_rddata_c = bus.mem_rddata;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.mem_address    = mem_address_c;
    assign bus.mem_byteenable = mem_byteenable_c;
    assign bus.mem_read       = mem_read_c;
    assign bus.mem_write      = mem_write_c;
    assign bus.mem_wrdata     = mem_wrdata_c;
    assign bus.ibus_stall     = ibus_stall_c;
    assign bus.dbus_stall     = dbus_stall_c;
    assign bus.ibus_rddata    = ibus_rddata_c;
    assign bus.dbus_rddata    = dbus_rddata_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= 2'b00;
            streak       <= 4'd0;
            protocol_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dbus_req && !ibus_starved) begin
                        state <= GNT_D;
                        owner <= 2'b10;
                        // Only count dbus wins that actually kept ibus waiting
                        if (!ibus_req)
                            streak <= 4'd0;
                        else if (streak != STREAK_MAX)
                            streak <= streak + 4'd1;
                    end else if (ibus_req) begin
                        state  <= GNT_I;
                        owner  <= 2'b01;
                        streak <= 4'd0;
                    end
                end
                GNT_I: begin
                    if (!ibus_req) begin
                        protocol_err <= 1'b1;
                        state        <= IDLE;
                        owner        <= 2'b00;
                    end else if (!bus.mem_waitrequest) begin
                        state <= IDLE;
                        owner <= 2'b00;
                    end
                end
                GNT_D: begin
                    if (!dbus_req) begin
                        protocol_err <= 1'b1;
                        state        <= IDLE;
                        owner        <= 2'b00;
                    end else if (!bus.mem_waitrequest) begin
                        state <= IDLE;
                        owner <= 2'b00;
                    end
                end
                default: begin
                    state <= IDLE;
                    owner <= 2'b00;
                end
            endcase
        end
    end

endmodule
